// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexers: mode encodings and a
// reusable round-robin search usable by any arbiter of up to MAX_CH requesters.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned MAX_CH   = 16;
    localparam int unsigned MAX_SELW = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_SELW-1:0] idx;
    } rr_pick_t;

    // Searches ptr+1, ptr+2, ... modulo n; the pointer itself is checked last.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]   valid,
                                         input logic [MAX_SELW-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t    res;
        int unsigned c;
        res = '0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            c = (32'(ptr) + k) % n;
            if (k <= n && !res.found && valid[c[MAX_SELW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = c[MAX_SELW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid channel after ptr_i.
// The pointer register lives in the instantiating block.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         valid_i,
    input  logic [$clog2(NCH)-1:0] ptr_i,
    output logic [$clog2(NCH)-1:0] gnt_o,
    output logic                   gnt_vld_o
);

    localparam int unsigned SELW = $clog2(NCH);

    logic [MAX_CH-1:0] valid_ext;
    rr_pick_t          pick;

    always_comb begin
        valid_ext          = '0;
        valid_ext[NCH-1:0] = valid_i;
        pick               = rr_pick(valid_ext, MAX_SELW'(ptr_i), NCH);
        gnt_o              = pick.idx[SELW-1:0];
        gnt_vld_o          = pick.found;
    end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel streaming multiplexer with fixed or round-robin selection and a
// single registered output stage behind valid/ready handshakes.
module mux_nch_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [$clog2(NCH)-1:0] sel,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned SELW = $clog2(NCH);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic [SELW-1:0]  rr_ptr_q;

    logic             adv;
    logic [SELW-1:0]  rr_gnt;
    logic             rr_gnt_vld;
    logic [SELW-1:0]  gnt;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .valid_i   (in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (rr_gnt),
        .gnt_vld_o (rr_gnt_vld)
    );

    assign adv = !out_valid_q || out_ready;

    // Out-of-range sel never grants, so an undefined in_valid[sel] is masked.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_gnt_vld;
        end else begin
            gnt     = sel;
            gnt_vld = (32'(sel) < NCH) && in_valid[sel];
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst && adv && gnt_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SELW'(NCH - 1);
        end else if (adv) begin
            if (gnt_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_ch_q    <= gnt;
                if (mode == MODE_RR) begin
                    rr_ptr_q <= gnt;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Scoreboard bench for mux_nch_rr: expected words are queued when a grant is
// expected and popped when the registered output presents them.
module tb_mux_nch_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mux_nch_rr #(
        .WIDTH (8),
        .NCH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'hF;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
        end
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        in_valid = 4'h0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed();
        exp_t e;
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        in_valid = 4'b0100;
        #1;
        n_vec++;
        if (in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL fixed_ready: got %b want 0100", in_ready);
        end
        sb.push_back('{d: 8'hA5, ch: 2'd2});
        tick();
        in_valid = 4'b0000;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL fixed_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
                n_err++;
                $display("FAIL fixed_out: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         out_valid, out_data, out_ch, e.d, e.ch);
            end
        end
    endtask

    task automatic test_fixed_idle();
        mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
        in_valid = 4'b1101;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_ready: got %b want 0000", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got v=%b rdy=%b want v=0 rdy=0000",
                         k, out_valid, in_ready);
            end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_rr_all();
        exp_t       e;
        logic [1:0] c;
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h43, 8'h42, 8'h41, 8'h40};
        in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            c = 2'(k % 4);
            #1;
            n_vec++;
            if (in_ready !== (4'b0001 << c)) begin
                n_err++;
                $display("FAIL rr_ready%0d: got %b want %b", k, in_ready, 4'b0001 << c);
            end
            sb.push_back('{d: 8'h40 + 8'(c), ch: c});
            tick();
            e = sb.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
                n_err++;
                $display("FAIL rr_out%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, out_valid, out_data, out_ch, e.d, e.ch);
            end
        end
        in_valid = 4'h0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drain: got v=%b want v=0", out_valid);
        end
    endtask

    task automatic test_rr_skip();
        exp_t       e;
        logic [1:0] chs[3];
        logic [3:0] vld[3];
        chs = '{2'd1, 2'd3, 2'd1};
        vld = '{4'b0010, 4'b1010, 4'b1010};
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h53, 8'h52, 8'h51, 8'h50};
        for (int k = 0; k < 3; k++) begin
            in_valid = vld[k];
            #1;
            n_vec++;
            if (in_ready !== (4'b0001 << chs[k])) begin
                n_err++;
                $display("FAIL skip_ready%0d: got %b want %b",
                         k, in_ready, 4'b0001 << chs[k]);
            end
            sb.push_back('{d: 8'h50 + 8'(chs[k]), ch: chs[k]});
            tick();
            e = sb.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
                n_err++;
                $display("FAIL skip_out%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, out_valid, out_data, out_ch, e.d, e.ch);
            end
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_data = {8'h00, 8'h00, 8'h00, 8'h11};
        in_valid = 4'b0001;
        sb.push_back('{d: 8'h11, ch: 2'd0});
        tick();
        in_data = {8'h00, 8'h00, 8'h00, 8'h22};
        sb.push_back('{d: 8'h22, ch: 2'd0});
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_ready%0d: got %b want 0000", k, in_ready);
            end
            tick();
            e = sb[0];
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, out_valid, out_data, out_ch, e.d, e.ch);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 0001", in_ready);
        end
        void'(sb.pop_front());
        tick();
        in_valid = 4'b0000;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
            n_err++;
            $display("FAIL bp_nobubble: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     out_valid, out_data, out_ch, e.d, e.ch);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got v=%b want v=0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        mode = 1'b1; out_ready = 1'b0;
        in_data = {8'h63, 8'h5A, 8'h61, 8'h60};
        in_valid = 4'b0100;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_err++;
            $display("FAIL mid_load: got v=%b d=%h want v=1 d=5a", out_valid, out_data);
        end
        rst = 1'b1;
        in_valid = 4'hF;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL mid_rst_out: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
        end
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_first_grant: got %b want 0001", in_ready);
        end
        sb.push_back('{d: 8'h60, ch: 2'd0});
        tick();
        in_valid = 4'h0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_ch !== e.ch) begin
            n_err++;
            $display("FAIL mid_out: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     out_valid, out_data, out_ch, e.d, e.ch);
        end
        tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_fixed_idle();
        test_rr_all();
        test_rr_skip();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nch_rr.md
Name: mux_nch_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with one registered output stage and valid/ready handshakes on every channel.
- Two selection modes: fixed (external `sel`) and round-robin (fair rotation over requesting channels).
- Successor to the plain combinational 4:1 select. Sits between several producer streams and a single consumer; used wherever a shared datapath must accept traffic from multiple sources.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1)
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), width of channel index (derived, localparam; not overridden)

Ports:
- clk        input   1           rising-edge clock
- rst        input   1           synchronous, active-high reset
- mode       input   1           0 = fixed select, 1 = round-robin
- sel        input   SELW        channel index used in fixed mode
- in_data    input   NCH*WIDTH   packed channel data; channel i at [i*WIDTH +: WIDTH]
- in_valid   input   NCH         per-channel valid
- in_ready   output  NCH         per-channel ready (combinational)
- out_data   output  WIDTH       registered output data
- out_ch     output  SELW        index of channel that supplied out_data
- out_valid  output  1           registered output valid
- out_ready  input   1           consumer ready

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1, so the first round-robin search starts at channel 0.
  - in_ready is all zero while rst=1.
- Advance:
  - `adv = !out_valid || out_ready`. The output register loads only when adv=1.
- Grant (combinational, evaluated every cycle):
  - Fixed mode: `gnt_vld = (sel < NCH) && in_valid[sel]`; `gnt = sel`. If sel >= NCH, there is no grant.
  - Round-robin mode: search channels rr_ptr+1, rr_ptr+2, ... modulo NCH. gnt is the first i with in_valid[i]=1, and gnt_vld=1 if any valid exists.
- Ready:
  - `in_ready[i] = adv && gnt_vld && (gnt == i)`. At most one bit is set (one-hot or zero).
  - in_ready must not depend on in_valid of channel i other than through grant selection.
- Transfer:
  - Channel i transfers when `in_valid[i] && in_ready[i]`.
  - On that edge: out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- adv=1 with no grant: out_valid <= 0. out_data and out_ch hold their old values.
- Stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold. All in_ready=0.
- Round-robin pointer:
  - rr_ptr <= gnt on every transfer in round-robin mode.
  - rr_ptr is unchanged in fixed mode and on cycles without a transfer.
- Timing: latency is 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle when out_ready is held at 1.
- Mode or sel changes: take effect in the same cycle's grant evaluation. There is no multi-beat locking. rr_ptr is retained across a mode switch.
- Fairness: in round-robin mode with all NCH channels valid continuously, each channel is granted exactly once per NCH transfers.
- Reset mid-operation: any pending output word is discarded. Producers must re-present their data; no transfer occurs on the reset edge.
- Producer obligation (protocol): in_valid must not drop, and in_data must not change, until that channel is granted. In fixed mode a channel not selected may wait indefinitely; this is permitted.

Decomposition:
- Shared package `mux_pkg`:
  - mode encodings MODE_FIXED=1'b0, MODE_RR=1'b1
  - function `rr_pick(valid, ptr)` returning index + found flag, reusable by other arbiters
- One natural sub-module: `rr_arbiter`.
  - Parametrised NCH; ports: valid in, ptr in, gnt out, gnt_vld out.
  - Purely combinational; the pointer register stays in the top.
- Top contains the grant mux, ready decode, output register and pointer register.

Test Plan:
- Reset, then fixed mode: sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1. Expect in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- Fixed mode, sel=1, in_valid=4'b1101 (ch1 idle). Expect in_ready=0 and out_valid falls to 0 after draining; channels 0, 2, 3 never granted.
- Round-robin, all four valid with distinct data, out_ready=1 for 8 cycles. Expect out_ch sequence 0,1,2,3,0,1,2,3 on back-to-back cycles.
- Round-robin, in_valid=4'b1010 after a grant to ch1. Expect next grant ch3, then ch1. Idle channels 0 and 2 are skipped.
- Backpressure: out_valid=1 with out_data=11, out_ready=0 for 3 cycles. Expect out_data/out_ch stable and in_ready=0. When out_ready rises, the new word loads on the same edge, giving no bubble.
- rst asserted while out_valid=1 and out_ready=0. Expect out_valid=0, out_data=0, out_ch=0 next cycle. The next round-robin grant with all valid is ch0.
